// File: rtl/kb_digit_entry.sv
// Decimal digit entry from PS/2 make codes: right-aligned digit buffer, edit keys,
// serial decimal-to-binary conversion on Enter and a clamped commit. Define KB_NUMPAD_EN to accept keypad digits and keypad Enter.
module kb_digit_entry #(
    parameter int MAX_DIGITS = 2,
    parameter int VALUE_W    = 7,
    parameter int MAX_VALUE  = 99
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [7:0]                        key_code,
    input  logic                              key_valid,
    output logic                              key_rd,
    output logic [VALUE_W-1:0]                value,
    output logic                              value_valid,
    output logic                              overflow,
    output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_cnt,
    output logic                              busy
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int AW = $clog2(10 ** MAX_DIGITS);

    typedef enum logic [1:0] {IDLE, ENTRY, CONV, DONE} state_t;

    state_t        state;
    logic [3:0]    slot [MAX_DIGITS];
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_next;
    logic [CW-1:0] step;
    logic [4:0]    dig;
    logic          is_bs;
    logic          is_esc;
    logic          is_enter;

    // Returns {is_digit, digit} for a make code.
    function automatic logic [4:0] decode_digit(input logic [7:0] c);
        logic [4:0] r;
        case (c)
            8'h45: r = {1'b1, 4'd0};
            8'h16: r = {1'b1, 4'd1};
            8'h1E: r = {1'b1, 4'd2};
            8'h26: r = {1'b1, 4'd3};
            8'h25: r = {1'b1, 4'd4};
            8'h2E: r = {1'b1, 4'd5};
            8'h36: r = {1'b1, 4'd6};
            8'h3D: r = {1'b1, 4'd7};
            8'h3E: r = {1'b1, 4'd8};
            8'h46: r = {1'b1, 4'd9};
`ifdef KB_NUMPAD_EN
            8'h70: r = {1'b1, 4'd0};
            8'h69: r = {1'b1, 4'd1};
            8'h72: r = {1'b1, 4'd2};
            8'h7A: r = {1'b1, 4'd3};
            8'h6B: r = {1'b1, 4'd4};
            8'h73: r = {1'b1, 4'd5};
            8'h74: r = {1'b1, 4'd6};
            8'h6C: r = {1'b1, 4'd7};
            8'h75: r = {1'b1, 4'd8};
            8'h7D: r = {1'b1, 4'd9};
`endif
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    function automatic logic [VALUE_W-1:0] clamp_value(input logic [AW-1:0] a);
        if (a > AW'(MAX_VALUE))
            return VALUE_W'(MAX_VALUE);
        return VALUE_W'(a);
    endfunction

    assign key_rd = reset && key_valid && (state == IDLE || state == ENTRY);
    assign dig    = decode_digit(key_code);
    assign is_bs  = (key_code == 8'h66);
    assign is_esc = (key_code == 8'h76);

`ifdef KB_NUMPAD_EN
    logic e0_seen;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            e0_seen <= 1'b0;
        else if (key_rd)
            e0_seen <= (key_code == 8'hE0);
    end

    // Keypad Enter arrives as E0 5A and behaves exactly like the main Enter.
    assign is_enter = (key_code == 8'h5A && !e0_seen) || (e0_seen && key_code == 8'h5A);
`else
    assign is_enter = (key_code == 8'h5A);
`endif

    // The most significant slot is consumed first; the buffer shifts up each step.
    assign acc_next = acc * AW'(10) + AW'(slot[MAX_DIGITS-1]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            for (int i = 0; i < MAX_DIGITS; i++) slot[i] <= 4'd0;
            digit_cnt   <= '0;
            acc         <= '0;
            step        <= '0;
            value       <= '0;
            value_valid <= 1'b0;
            overflow    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            case (state)
                IDLE, ENTRY: begin
                    if (key_rd) begin
                        if (dig[4]) begin
                            if (digit_cnt < CW'(MAX_DIGITS)) begin
                                for (int i = MAX_DIGITS - 1; i > 0; i--) slot[i] <= slot[i-1];
                                slot[0]   <= dig[3:0];
                                digit_cnt <= digit_cnt + CW'(1);
                                state     <= ENTRY;
                            end
                        end else if (is_bs) begin
                            if (digit_cnt != '0) begin
                                for (int i = 0; i < MAX_DIGITS - 1; i++) slot[i] <= slot[i+1];
                                slot[MAX_DIGITS-1] <= 4'd0;
                                digit_cnt          <= digit_cnt - CW'(1);
                                if (digit_cnt == CW'(1)) state <= IDLE;
                            end
                        end else if (is_esc) begin
                            for (int i = 0; i < MAX_DIGITS; i++) slot[i] <= 4'd0;
                            digit_cnt <= '0;
                            state     <= IDLE;
                        end else if (is_enter && state == ENTRY) begin
                            acc   <= '0;
                            step  <= '0;
                            busy  <= 1'b1;
                            state <= CONV;
                        end
                    end
                end
                CONV: begin
                    acc <= acc_next;
                    for (int i = MAX_DIGITS - 1; i > 0; i--) slot[i] <= slot[i-1];
                    slot[0] <= 4'd0;
                    step    <= step + CW'(1);
                    if (step == CW'(MAX_DIGITS - 1)) state <= DONE;
                end
                DONE: begin
                    value       <= clamp_value(acc);
                    overflow    <= (acc > AW'(MAX_VALUE));
                    value_valid <= 1'b1;
                    for (int i = 0; i < MAX_DIGITS; i++) slot[i] <= 4'd0;
                    digit_cnt   <= '0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kb_digit_entry.sv
// Bench for kb_digit_entry: a default instance and a MAX_VALUE=63/VALUE_W=6 instance share one
// modelled kb_code key FIFO; expected commits go through a scoreboard.
module tb_kb_digit_entry;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       key_valid = 1'b0;

    logic       key_rd_a, vv_a, ovf_a, busy_a;
    logic [6:0] value_a;
    logic [1:0] cnt_a;
    logic       key_rd_b, vv_b, ovf_b, busy_b;
    logic [5:0] value_b;
    logic [1:0] cnt_b;

    always #5 clk = ~clk;

    kb_digit_entry dut (
        .clk(clk), .reset(reset), .key_code(key_code), .key_valid(key_valid),
        .key_rd(key_rd_a), .value(value_a), .value_valid(vv_a), .overflow(ovf_a),
        .digit_cnt(cnt_a), .busy(busy_a)
    );

    kb_digit_entry #(.MAX_DIGITS(2), .VALUE_W(6), .MAX_VALUE(63)) dut63 (
        .clk(clk), .reset(reset), .key_code(key_code), .key_valid(key_valid),
        .key_rd(key_rd_b), .value(value_b), .value_valid(vv_b), .overflow(ovf_b),
        .digit_cnt(cnt_b), .busy(busy_b)
    );

    logic [7:0] kq[$];
    logic [7:0] popped[$];
    bit         pop_pend = 1'b0;
    int         cyc = 0;
    int         enter_edge = 0;
    int         pulse_cnt = 0;
    int         last_lat = 0;
    bit         rd_while_busy = 1'b0;
    int         n_vec = 0;
    int         n_bad = 0;
    int         sb_va[$], sb_vb[$];
    bit         sb_oa[$], sb_ob[$];

    always @(posedge clk) cyc++;

    // kb_code FIFO model: head presented from the falling edge, popped after a rising edge with key_rd.
    always @(negedge clk) begin
        if (pop_pend) popped.push_back(kq.pop_front());
        key_valid = (kq.size() != 0);
        key_code  = key_valid ? kq[0] : 8'h00;
        #2;
        pop_pend = key_rd_a;
        if (key_rd_a && key_code == 8'h5A) enter_edge = cyc + 1;
    end

    always @(negedge clk) begin
        if (vv_a) begin
            pulse_cnt++;
            last_lat = cyc - enter_edge;
        end
        if (busy_a && key_rd_a) rd_while_busy = 1'b1;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation bound reached at cycle %0d, want completion", cyc);
        $fatal(1);
    end

    task automatic push(input logic [7:0] c);
        kq.push_back(c);
    endtask

    task automatic sb_push(input int va, input bit oa, input int vb, input bit ob);
        sb_va.push_back(va); sb_oa.push_back(oa);
        sb_vb.push_back(vb); sb_ob.push_back(ob);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #3;
            if (kq.size() == 0 && !pop_pend) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_pulse(output bit got);
        int s;
        s   = pulse_cnt;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (pulse_cnt != s) begin
                got = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        bit got;
        reset = 1'b0;
        tick(3);
        n_vec += 3;
        if (value_a !== 7'd0 || vv_a !== 1'b0 || ovf_a !== 1'b0) begin
            n_bad++; $display("FAIL reset_outputs: value=%0d valid=%0b ovf=%0b, want 0/0/0", value_a, vv_a, ovf_a);
        end
        if (cnt_a !== 2'd0 || busy_a !== 1'b0) begin
            n_bad++; $display("FAIL reset_ctrl: cnt=%0d busy=%0b, want 0/0", cnt_a, busy_a);
        end
        if (value_b !== 6'd0 || cnt_b !== 2'd0 || busy_b !== 1'b0) begin
            n_bad++; $display("FAIL reset_dut63: value=%0d cnt=%0d busy=%0b, want 0/0/0", value_b, cnt_b, busy_b);
        end
        reset = 1'b1;
        push(8'h25); push(8'h1E); push(8'h5A);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick(1);
            got = busy_a;
        end
        n_vec++;
        if (!got) begin
            n_bad++; $display("FAIL reset_reach_conv: busy=%0b, want 1 after Enter", busy_a);
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if (busy_a !== 1'b0 || cnt_a !== 2'd0 || busy_b !== 1'b0) begin
            n_bad++; $display("FAIL reset_abort: busy=%0b cnt=%0d busy63=%0b, want 0/0/0", busy_a, cnt_a, busy_b);
        end
        got = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick(1);
            if (vv_a || vv_b) got = 1'b1;
        end
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (vv_a || vv_b) got = 1'b1;
        end
        n_vec += 2;
        if (got) begin
            n_bad++; $display("FAIL reset_no_pulse: value_valid seen=%0b, want 0", got);
        end
        if (value_a !== 7'd0 || ovf_a !== 1'b0) begin
            n_bad++; $display("FAIL reset_value: value=%0d ovf=%0b, want 0/0", value_a, ovf_a);
        end
    endtask

    task automatic test_basic();
        bit got;
        int ea, eb;
        bit oa, ob;
        push(8'h25); push(8'h1E); push(8'h5A);
        sb_push(42, 1'b0, 42, 1'b0);
        wait_pulse(got);
        ea = sb_va.pop_front(); oa = sb_oa.pop_front(); eb = sb_vb.pop_front(); ob = sb_ob.pop_front();
        n_vec += 5;
        if (!got) begin
            n_bad++; $display("FAIL basic_pulse: no value_valid seen, want one for %0d", ea);
        end
        if (value_a !== 7'(ea) || ovf_a !== oa) begin
            n_bad++; $display("FAIL basic_a: value=%0d ovf=%0b, want %0d/%0b", value_a, ovf_a, ea, oa);
        end
        if (value_b !== 6'(eb) || ovf_b !== ob) begin
            n_bad++; $display("FAIL basic_b: value=%0d ovf=%0b, want %0d/%0b", value_b, ovf_b, eb, ob);
        end
        if (last_lat != 3) begin
            n_bad++; $display("FAIL basic_latency: %0d cycles after Enter pop, want 3", last_lat);
        end
        if (cnt_a !== 2'd0 || busy_a !== 1'b0) begin
            n_bad++; $display("FAIL basic_done_ctrl: cnt=%0d busy=%0b, want 0/0", cnt_a, busy_a);
        end
        tick(1);
        n_vec++;
        if (vv_a !== 1'b0 || value_a !== 7'd42) begin
            n_bad++; $display("FAIL basic_one_cycle: valid=%0b value=%0d, want 0/42", vv_a, value_a);
        end
    endtask

    task automatic test_overflow();
        bit got;
        int ea, eb;
        bit oa, ob;
        push(8'h3D); push(8'h2E); push(8'h5A); sb_push(75, 1'b0, 63, 1'b1);
        push(8'h1E); push(8'h5A);              sb_push(2,  1'b0, 2,  1'b0);
        push(8'h36); push(8'h26); push(8'h5A); sb_push(63, 1'b0, 63, 1'b0);
        push(8'h36); push(8'h25); push(8'h5A); sb_push(64, 1'b0, 63, 1'b1);
        push(8'h46); push(8'h45); push(8'h5A); sb_push(90, 1'b0, 63, 1'b1);
        for (int k = 0; k < 5; k++) begin
            wait_pulse(got);
            ea = sb_va.pop_front(); oa = sb_oa.pop_front(); eb = sb_vb.pop_front(); ob = sb_ob.pop_front();
            n_vec += 4;
            if (!got) begin
                n_bad++; $display("FAIL ovf_pulse: commit %0d not seen, want value %0d", k, ea);
            end
            if (value_a !== 7'(ea) || ovf_a !== oa) begin
                n_bad++; $display("FAIL ovf_a: commit %0d value=%0d ovf=%0b, want %0d/%0b", k, value_a, ovf_a, ea, oa);
            end
            if (value_b !== 6'(eb) || ovf_b !== ob) begin
                n_bad++; $display("FAIL ovf_b: commit %0d value=%0d ovf=%0b, want %0d/%0b", k, value_b, ovf_b, eb, ob);
            end
            if (last_lat != 3) begin
                n_bad++; $display("FAIL ovf_latency: commit %0d took %0d cycles, want 3", k, last_lat);
            end
        end
    endtask

    task automatic test_edit();
        bit got, ok;
        int p0, ea, eb;
        bit oa, ob;
        push(8'h16); push(8'h1E); push(8'h26);
        drain(ok);
        n_vec += 2;
        if (!ok || cnt_a !== 2'd2) begin
            n_bad++; $display("FAIL edit_drop_third: cnt=%0d drained=%0b, want 2/1", cnt_a, ok);
        end
        if (ovf_b !== 1'b1 || value_b !== 6'd63) begin
            n_bad++; $display("FAIL edit_hold_ovf: value=%0d ovf=%0b, want 63/1", value_b, ovf_b);
        end
        push(8'h66);
        drain(ok);
        n_vec++;
        if (cnt_a !== 2'd1) begin
            n_bad++; $display("FAIL edit_backspace: cnt=%0d, want 1", cnt_a);
        end
        push(8'h25); push(8'h5A);
        sb_push(14, 1'b0, 14, 1'b0);
        wait_pulse(got);
        ea = sb_va.pop_front(); oa = sb_oa.pop_front(); eb = sb_vb.pop_front(); ob = sb_ob.pop_front();
        n_vec += 2;
        if (!got || value_a !== 7'(ea) || ovf_a !== oa) begin
            n_bad++; $display("FAIL edit_value_a: value=%0d ovf=%0b seen=%0b, want %0d/%0b", value_a, ovf_a, got, ea, oa);
        end
        if (value_b !== 6'(eb) || ovf_b !== ob) begin
            n_bad++; $display("FAIL edit_value_b: value=%0d ovf=%0b, want %0d/%0b", value_b, ovf_b, eb, ob);
        end
        p0 = pulse_cnt;
        push(8'h16); push(8'h76);
        drain(ok);
        tick(5);
        n_vec++;
        if (cnt_a !== 2'd0 || pulse_cnt != p0 || value_a !== 7'd14) begin
            n_bad++; $display("FAIL edit_esc: cnt=%0d pulses=%0d value=%0d, want 0/0/14", cnt_a, pulse_cnt - p0, value_a);
        end
        push(8'h66); push(8'h16); push(8'h66); push(8'h5A);
        drain(ok);
        tick(5);
        n_vec++;
        if (cnt_a !== 2'd0 || pulse_cnt != p0 || busy_a !== 1'b0) begin
            n_bad++; $display("FAIL edit_bs_to_idle: cnt=%0d pulses=%0d busy=%0b, want 0/0/0", cnt_a, pulse_cnt - p0, busy_a);
        end
    endtask

    task automatic test_back_to_back();
        bit got, ok, same;
        int p0, ea, eb;
        bit oa, ob;
        logic [7:0] seq[6];
        seq = '{8'h25, 8'h1E, 8'h5A, 8'h16, 8'h26, 8'h5A};
        popped.delete();
        rd_while_busy = 1'b0;
        foreach (seq[i]) push(seq[i]);
        sb_push(42, 1'b0, 42, 1'b0);
        sb_push(13, 1'b0, 13, 1'b0);
        for (int k = 0; k < 2; k++) begin
            wait_pulse(got);
            ea = sb_va.pop_front(); oa = sb_oa.pop_front(); eb = sb_vb.pop_front(); ob = sb_ob.pop_front();
            n_vec += 3;
            if (!got) begin
                n_bad++; $display("FAIL b2b_pulse: commit %0d not seen, want value %0d", k, ea);
            end
            if (value_a !== 7'(ea) || ovf_a !== oa) begin
                n_bad++; $display("FAIL b2b_a: commit %0d value=%0d ovf=%0b, want %0d/%0b", k, value_a, ovf_a, ea, oa);
            end
            if (value_b !== 6'(eb) || ovf_b !== ob) begin
                n_bad++; $display("FAIL b2b_b: commit %0d value=%0d ovf=%0b, want %0d/%0b", k, value_b, ovf_b, eb, ob);
            end
        end
        drain(ok);
        same = (popped.size() == 6);
        for (int i = 0; i < popped.size() && i < 6; i++)
            if (popped[i] !== seq[i]) same = 1'b0;
        n_vec += 2;
        if (!same) begin
            n_bad++; $display("FAIL b2b_pop_order: %0d codes popped in order=%0b, want 6 in order", popped.size(), same);
        end
        if (rd_while_busy) begin
            n_bad++; $display("FAIL b2b_rd_in_conv: key_rd asserted while busy=%0b, want never", rd_while_busy);
        end
        p0 = pulse_cnt;
        push(8'h5A);
        drain(ok);
        tick(5);
        n_vec++;
        if (pulse_cnt != p0 || busy_a !== 1'b0) begin
            n_bad++; $display("FAIL idle_enter: pulses=%0d busy=%0b, want 0/0", pulse_cnt - p0, busy_a);
        end
    endtask

    task automatic test_numpad();
        bit got, ok;
        int p0;
        p0 = pulse_cnt;
        push(8'h69); push(8'h72); push(8'hE0); push(8'h5A);
`ifdef KB_NUMPAD_EN
        wait_pulse(got);
        n_vec += 2;
        if (!got || value_a !== 7'd12 || ovf_a !== 1'b0) begin
            n_bad++; $display("FAIL numpad_a: value=%0d ovf=%0b seen=%0b, want 12/0/1", value_a, ovf_a, got);
        end
        if (value_b !== 6'd12 || ovf_b !== 1'b0) begin
            n_bad++; $display("FAIL numpad_b: value=%0d ovf=%0b, want 12/0", value_b, ovf_b);
        end
`else
        drain(ok);
        tick(5);
        got = (pulse_cnt != p0);
        n_vec += 2;
        if (got) begin
            n_bad++; $display("FAIL numpad_off_pulse: pulses=%0d, want 0", pulse_cnt - p0);
        end
        if (cnt_a !== 2'd0 || value_a !== 7'd13) begin
            n_bad++; $display("FAIL numpad_off_cnt: cnt=%0d value=%0d, want 0/13", cnt_a, value_a);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_edit();
        test_back_to_back();
        test_numpad();
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
